// File: rtl/i2s_speaker_tx.sv
// I2S serialiser for the Pmod I2S2 DAC: one free-running divider derives MCLK,
// SCK, LRCK and the slot timing; a left/right pair is captured atomically per frame.
module i2s_speaker_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_left,
  input  logic [DATA_W-1:0] audio_right,
  input  logic              mute,
  output logic              audio_mclk,
  output logic              audio_sck,
  output logic              audio_lrck,
  output logic              audio_sdin,
  output logic              frame_tick
);

  logic [8:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] w_q, w_d;
  logic                sdin_q, sdin_d;

  logic       load_edge;
  logic       slot_edge;
  logic [4:0] slot_next;
  logic [4:0] bit_idx;

  assign load_edge = (cnt_q == 9'd511);
  assign slot_edge = (cnt_q[3:0] == 4'hF);
  assign slot_next = cnt_q[8:4] + 5'd1;
  // Slot n carries W[32-n]; the 5-bit wrap maps slot 0 onto W[0], the previous
  // frame's right LSB, which is still in W because the load is non-blocking.
  assign bit_idx   = 5'd0 - slot_next;

  always_comb begin
    cnt_d  = cnt_q + 9'd1;
    w_d    = w_q;
    sdin_d = sdin_q;
    if (load_edge) begin
      w_d = mute ? '0 : {audio_left, audio_right};
    end
    if (slot_edge) begin
      sdin_d = w_q[bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      w_q    <= '0;
      sdin_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      sdin_q <= sdin_d;
    end
  end

  assign audio_mclk = cnt_q[1];
  assign audio_sck  = cnt_q[3];
  assign audio_lrck = cnt_q[8];
  assign audio_sdin = sdin_q;
  assign frame_tick = load_edge;

endmodule

// File: tb/tb_i2s_speaker_tx.sv
// Directed bench for i2s_speaker_tx: clock ratios, frame capture, mid-frame
// input changes, mute, mid-frame reset and the slot-0 carry-over bit.
module tb_i2s_speaker_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        mute;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int phase    = 0;

  i2s_speaker_tx #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .mute       (mute),
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 512;
  endtask

  // Always advances at least one clock, so step_to(0) crosses a load edge.
  task automatic step_to(input int p);
    step();
    while (phase != p) step();
  endtask

  // Samples SDIN on the SCK high phase of slots 1..31 and slot 0 of the next
  // frame; optionally replaces the input pair just before sampling slot chg_slot.
  task automatic sample_frame(input int chg_slot, input logic [31:0] chg_val,
                              output logic [31:0] bits);
    while (phase != 24) step();
    check("sck_high_at_sample", {31'd0, audio_sck}, 32'd1);
    for (int i = 1; i <= 32; i++) begin
      if (i == chg_slot) {audio_left, audio_right} = chg_val;
      bits[32 - i] = audio_sdin;
      if (i < 32) repeat (16) step();
    end
  endtask

  initial begin
    logic [31:0] fr;
    int mclk_hi, sck_hi, lrck_hi, mclk_rise, sck_rise, lrck_rise, ft_cnt, sdin_ones;
    logic pm, ps, pl;
    int  waited;
    bit  found;

    rst = 1'b1; mute = 1'b0; audio_left = 16'hFFFF; audio_right = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mclk", {31'd0, audio_mclk}, 32'd0);
    check("rst_sck",  {31'd0, audio_sck},  32'd0);
    check("rst_lrck", {31'd0, audio_lrck}, 32'd0);
    check("rst_sdin", {31'd0, audio_sdin}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    phase = 0;

    // Free run: ratios, duty, tick positions, zero first frame
    mclk_hi = 0; sck_hi = 0; lrck_hi = 0; mclk_rise = 0; sck_rise = 0; lrck_rise = 0;
    ft_cnt = 0; sdin_ones = 0; pm = 0; ps = 0; pl = 0;
    for (int s = 1; s <= 2048; s++) begin
      step();
      mclk_hi += audio_mclk; sck_hi += audio_sck; lrck_hi += audio_lrck;
      if (audio_mclk && !pm) mclk_rise++;
      if (audio_sck  && !ps) sck_rise++;
      if (audio_lrck && !pl) lrck_rise++;
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
      if (frame_tick) begin
        ft_cnt++;
        check("tick_position", s % 512, 511);
      end
      if (s <= 527) sdin_ones += audio_sdin;
    end
    check("mclk_rises", mclk_rise, 512);
    check("sck_rises",  sck_rise,  128);
    check("lrck_rises", lrck_rise, 4);
    check("mclk_duty",  mclk_hi,   1024);
    check("sck_duty",   sck_hi,    1024);
    check("lrck_duty",  lrck_hi,   1024);
    check("tick_count", ft_cnt,    4);
    check("first_frame_zero", sdin_ones, 0);

    // Basic frame serialisation
    audio_left = 16'hA5F0; audio_right = 16'h0F0F;
    step_to(0);
    sample_frame(-1, 32'd0, fr);
    check("frame_A5F0_0F0F", fr, 32'hA5F0_0F0F);

    // Mid-frame input change is deferred to the next frame
    audio_left = 16'h1234; audio_right = 16'h0000;
    step_to(0);
    sample_frame(5, 32'hFFFF_0000, fr);
    check("midframe_hold", fr, 32'h1234_0000);
    sample_frame(-1, 32'd0, fr);
    check("midframe_next", fr, 32'hFFFF_0000);

    // One-clock mute at the load edge
    audio_left = 16'h7FFF; audio_right = 16'h7FFF;
    step_to(511);
    check("tick_before_load", {31'd0, frame_tick}, 32'd1);
    mute = 1'b1;
    step();
    mute = 1'b0;
    check("tick_after_load", {31'd0, frame_tick}, 32'd0);
    sample_frame(-1, 32'd0, fr);
    check("muted_frame", fr, 32'h0000_0000);
    sample_frame(-1, 32'd0, fr);
    check("unmuted_frame", fr, 32'h7FFF_7FFF);

    // Reset mid-frame at cnt=300
    audio_left = 16'h8001; audio_right = 16'h8001;
    step_to(0);
    step_to(300);
    check("pre_rst_lrck", {31'd0, audio_lrck}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    phase = 0;
    check("midrst_mclk", {31'd0, audio_mclk}, 32'd0);
    check("midrst_sck",  {31'd0, audio_sck},  32'd0);
    check("midrst_lrck", {31'd0, audio_lrck}, 32'd0);
    check("midrst_sdin", {31'd0, audio_sdin}, 32'd0);
    check("midrst_tick", {31'd0, frame_tick}, 32'd0);
    waited = 0; found = 0; sdin_ones = 0;
    while (!found && waited < 1000) begin
      step();
      waited++;
      if (waited == 2) check("restart_mclk", {31'd0, audio_mclk}, 32'd1);
      if (waited == 8) check("restart_sck",  {31'd0, audio_sck},  32'd1);
      sdin_ones += audio_sdin;
      if (frame_tick) found = 1;
    end
    check("tick_after_release", waited, 511);
    check("dropped_bits_zero", sdin_ones, 0);
    phase = 511;
    sample_frame(-1, 32'd0, fr);
    check("post_rst_frame", fr, 32'h8001_8001);

    // Slot 0 carries the previous right LSB while W holds the new pair
    audio_left = 16'h0000; audio_right = 16'h0001;
    step_to(0);
    sample_frame(5, 32'h8000_0000, fr);
    check("slot0_carry_frame", fr, 32'h0000_0001);
    sample_frame(-1, 32'd0, fr);
    check("next_pair_frame", fr, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
